// File: rtl/biotensor_mac_sequencer_if.sv
// Handshake and MAC-side signal bundle for the bioTensor dot-product sequencer.
// The master side offers commands and operands, models the MAC and consumes result bytes.
interface biotensor_mac_sequencer_if #(
   parameter int ACC_W = 20
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_len;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_a;
   logic [7:0]       in_b;
   logic             mac_clr;
   logic             mac_en;
   logic [7:0]       mac_a;
   logic [7:0]       mac_b;
   logic [ACC_W-1:0] mac_acc;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic             busy;
   logic             err_len;

   modport master (
      output cmd_valid, cmd_len, in_valid, in_a, in_b, mac_acc, out_ready,
      input  cmd_ready, in_ready, mac_clr, mac_en, mac_a, mac_b,
             out_valid, out_data, out_last, busy, err_len
   );

   modport slave (
      input  cmd_valid, cmd_len, in_valid, in_a, in_b, mac_acc, out_ready,
      output cmd_ready, in_ready, mac_clr, mac_en, mac_a, mac_b,
             out_valid, out_data, out_last, busy, err_len
   );
endinterface

// File: rtl/biotensor_mac_sequencer.sv
// Sequencer for the bioTensor dot-product MAC: takes a length command, streams operand
// pairs into the external MAC, waits out its latency and returns the sum as LSB-first bytes.
//
// state | meaning
// IDLE  | waiting for a length command
// LOAD  | feeding operand pairs to the MAC until len beats taken
// DRAIN | waiting MAC_LAT cycles for the accumulator to settle
// OUT   | serialising captured accumulator bytes
module biotensor_mac_sequencer #(
   parameter int VEC_LEN = 4,
   parameter int ACC_W   = 20,
   parameter int MAC_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   biotensor_mac_sequencer_if.slave bus
);
   localparam int NBYTES = (ACC_W + 7) / 8;
   localparam int SH_W   = 8 * NBYTES;
   localparam int LEN_W  = $clog2(VEC_LEN + 1);
   localparam int WAIT_W = $clog2(MAC_LAT + 1);
   localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

   state_t            state, state_nx;
   logic [LEN_W-1:0]  len_q, beat_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [BYTE_W-1:0] byte_idx;
   logic [SH_W-1:0]   shift_q;
   logic              err_q;

   logic live, cmd_legal, last_byte;
   logic cmd_fire, beat_fire, drain_done, byte_fire;
   logic cmd_ready, in_ready, mac_clr, mac_en, out_valid;

   // Gating with rst_n keeps every output low while reset is asserted.
   assign live      = ena & rst_n;
   assign cmd_legal = (bus.cmd_len != '0) && (32'(bus.cmd_len) <= VEC_LEN);
   assign last_byte = (byte_idx == BYTE_W'(NBYTES - 1));

   always_comb begin
      state_nx   = state;
      cmd_ready  = 1'b0;
      in_ready   = 1'b0;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      out_valid  = 1'b0;
      cmd_fire   = 1'b0;
      beat_fire  = 1'b0;
      drain_done = 1'b0;
      byte_fire  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = live;
            cmd_fire  = live & bus.cmd_valid;
            if (cmd_fire && cmd_legal) begin
               mac_clr  = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            in_ready  = live;
            beat_fire = live & bus.in_valid;
            mac_en    = beat_fire;
            if (beat_fire && (beat_cnt + LEN_W'(1) == len_q))
               state_nx = DRAIN;
         end
         DRAIN: begin
            drain_done = live && (wait_cnt == WAIT_W'(MAC_LAT - 1));
            if (drain_done)
               state_nx = OUT;
         end
         OUT: begin
            out_valid = live;
            byte_fire = live & bus.out_ready;
            if (byte_fire && last_byte)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         len_q    <= '0;
         beat_cnt <= '0;
         wait_cnt <= '0;
         byte_idx <= '0;
         shift_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nx;
         err_q <= cmd_fire & ~cmd_legal;
         if (mac_clr) begin
            len_q    <= LEN_W'(bus.cmd_len);
            beat_cnt <= '0;
         end
         if (beat_fire) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            wait_cnt <= '0;
         end
         if ((state == DRAIN) && live && !drain_done)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         // Zero-extend so unused top bits of the last byte read as 0.
         if (drain_done) begin
            shift_q  <= SH_W'(bus.mac_acc);
            byte_idx <= '0;
         end
         if (byte_fire) begin
            shift_q  <= shift_q >> 8;
            byte_idx <= byte_idx + BYTE_W'(1);
         end
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.in_ready  = in_ready;
   assign bus.mac_clr   = mac_clr;
   assign bus.mac_en    = mac_en;
   assign bus.mac_a     = live ? bus.in_a : 8'h00;
   assign bus.mac_b     = live ? bus.in_b : 8'h00;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = shift_q[7:0];
   assign bus.out_last  = (state == OUT) && last_byte;
   assign bus.busy      = (state != IDLE);
   assign bus.err_len   = err_q;
endmodule

// File: tb/tb_biotensor_mac_sequencer.sv
// Bench for biotensor_mac_sequencer: transaction-level model checked every cycle,
// plus literal expected byte streams for each directed scenario.
module tb_biotensor_mac_sequencer;
   localparam int NBYTES  = 3;
   localparam int MAC_LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b0;
   always #5 clk = ~clk;

   biotensor_mac_sequencer_if #(.ACC_W(20)) bus();

   biotensor_mac_sequencer #(.VEC_LEN(4), .ACC_W(20), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // External MAC: clear/accumulate at the edge, one extra pipeline register -> MAC_LAT=2.
   logic [19:0] acc_int, acc_d;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_int <= '0;
         acc_d   <= '0;
      end else begin
         if (bus.mac_clr)     acc_int <= '0;
         else if (bus.mac_en) acc_int <= acc_int + 20'(bus.mac_a) * 20'(bus.mac_b);
         acc_d <= acc_int;
      end
   end
   assign bus.mac_acc = acc_d;

   // Transaction model: one in-flight dot product, its beats, sum, settle time and byte index.
   logic        m_busy, m_err;
   logic [2:0]  m_len, m_beats;
   logic [23:0] m_sum;
   int          m_drain, m_idx;

   function automatic logic len_ok(input logic [2:0] l);
      return (l >= 3'd1) && (l <= 3'd4);
   endfunction

   logic tb_live, exp_cmd_ready, exp_in_ready, exp_out_valid, exp_mac_clr, exp_mac_en;
   logic [7:0] exp_out_data;
   logic exp_out_last;
   assign tb_live       = ena & rst_n;
   assign exp_cmd_ready = tb_live & ~m_busy;
   assign exp_in_ready  = tb_live & m_busy & (m_beats < m_len);
   assign exp_out_valid = tb_live & m_busy & (m_beats == m_len) & (m_drain >= MAC_LAT);
   assign exp_mac_clr   = exp_cmd_ready & bus.cmd_valid & len_ok(bus.cmd_len);
   assign exp_mac_en    = exp_in_ready & bus.in_valid;
   assign exp_out_data  = 8'(m_sum >> (8 * m_idx));
   assign exp_out_last  = (m_idx == NBYTES - 1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_err <= 1'b0; m_len <= '0; m_beats <= '0;
         m_sum <= '0; m_drain <= 0; m_idx <= 0;
      end else begin
         m_err <= exp_cmd_ready & bus.cmd_valid & ~len_ok(bus.cmd_len);
         if (exp_mac_clr) begin
            m_busy <= 1'b1; m_len <= bus.cmd_len; m_beats <= '0;
            m_sum <= '0; m_drain <= 0; m_idx <= 0;
         end
         if (exp_mac_en) begin
            m_beats <= m_beats + 3'd1;
            m_sum   <= m_sum + 24'(bus.in_a) * 24'(bus.in_b);
            m_drain <= 0;
         end else if (ena && m_busy && (m_beats == m_len) && (m_drain < MAC_LAT)) begin
            m_drain <= m_drain + 1;
         end
         if (exp_out_valid && bus.out_ready) begin
            if (m_idx == NBYTES - 1) m_busy <= 1'b0;
            else                     m_idx  <= m_idx + 1;
         end
      end
   end

   // Per-cycle compare and observation counters.
   logic [7:0] rx_q[$];
   logic       last_q[$];
   int en_cnt = 0, err_cnt = 0, clr_cnt = 0, ov_cnt = 0, frozen_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
         check("rst_in_ready",  32'(bus.in_ready),  0);
         check("rst_out_valid", 32'(bus.out_valid), 0);
         check("rst_mac_clr",   32'(bus.mac_clr),   0);
         check("rst_mac_en",    32'(bus.mac_en),    0);
         check("rst_busy",      32'(bus.busy),      0);
         check("rst_err_len",   32'(bus.err_len),   0);
         check("rst_out_last",  32'(bus.out_last),  0);
         check("rst_out_data",  32'(bus.out_data),  0);
      end else begin
         check("cmd_ready", 32'(bus.cmd_ready), 32'(exp_cmd_ready));
         check("in_ready",  32'(bus.in_ready),  32'(exp_in_ready));
         check("out_valid", 32'(bus.out_valid), 32'(exp_out_valid));
         check("mac_clr",   32'(bus.mac_clr),   32'(exp_mac_clr));
         check("mac_en",    32'(bus.mac_en),    32'(exp_mac_en));
         check("busy",      32'(bus.busy),      32'(m_busy));
         check("err_len",   32'(bus.err_len),   32'(m_err));
         check("mac_a",     32'(bus.mac_a),     32'(ena ? bus.in_a : 8'h00));
         check("mac_b",     32'(bus.mac_b),     32'(ena ? bus.in_b : 8'h00));
         if (exp_out_valid) begin
            check("out_data", 32'(bus.out_data), 32'(exp_out_data));
            check("out_last", 32'(bus.out_last), 32'(exp_out_last));
         end
         if (bus.out_valid && bus.out_ready) begin
            rx_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
         end
         if (bus.mac_en)                frozen_cnt += ena ? 0 : 1;
         if (bus.mac_en)                en_cnt++;
         if (bus.err_len)               err_cnt++;
         if (bus.mac_clr)               clr_cnt++;
         if (bus.out_valid)             ov_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_cmd(input logic [2:0] len);
      bit done = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = len;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) done = 1'b1;
      end
      tick();
      bus.cmd_valid = 1'b0;
      if (!done) check("cmd_timeout", 0, 1);
   endtask

   task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1'b1;
      end
      tick();
      bus.in_valid = 1'b0;
      if (!done) check("pair_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!bus.busy) done = 1'b1;
      end
      tick();
      if (!done) check("idle_timeout", 0, 1);
   endtask

   task automatic expect_bytes(input string name, input logic [23:0] exp);
      logic [2:0] exp_last;
      exp_last = 3'b100;
      check({name, "_count"}, 32'(rx_q.size()), NBYTES);
      if (rx_q.size() == NBYTES) begin
         for (int i = 0; i < NBYTES; i++) begin
            check({name, "_byte"}, 32'(rx_q[i]), 32'(exp[8*i +: 8]));
            check({name, "_last"}, 32'(last_q[i]), 32'(exp_last[i]));
         end
      end
      rx_q.delete();
      last_q.delete();
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_len = '0;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
      bus.out_ready = 1'b1;
      ena = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_cmd_ready", 32'(bus.cmd_ready), 1);
      check("idle_busy", 32'(bus.busy), 0);
      tick();

      // 1: len 3 back-to-back -> 6+20+42 = 68
      send_cmd(3'd3);
      send_pair(8'd2, 8'd3); send_pair(8'd4, 8'd5); send_pair(8'd6, 8'd7);
      wait_idle();
      expect_bytes("t1", 24'h000044);
      check("t1_busy_after", 32'(bus.busy), 0);

      // 2: len 4 of 255*255 -> 260100
      send_cmd(3'd4);
      for (int i = 0; i < 4; i++) send_pair(8'd255, 8'd255);
      wait_idle();
      expect_bytes("t2", 24'h03F804);

      // 3: rejected lengths then len 1 (9,9) -> 81
      err_cnt = 0; clr_cnt = 0;
      send_cmd(3'd0);
      send_cmd(3'd5);
      repeat (2) tick();
      check("t3_err_pulses", 32'(err_cnt), 2);
      check("t3_no_clr", 32'(clr_cnt), 0);
      check("t3_busy", 32'(bus.busy), 0);
      send_cmd(3'd1);
      send_pair(8'd9, 8'd9);
      wait_idle();
      expect_bytes("t3", 24'h000051);

      // 4: len 2 with gaps, output stalls -> 200+1200 = 1400
      en_cnt = 0;
      bus.out_ready = 1'b0;
      send_cmd(3'd2);
      repeat (2) tick();
      send_pair(8'd10, 8'd20);
      repeat (3) tick();
      send_pair(8'd30, 8'd40);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
         end
         if (!seen) check("t4_out_timeout", 0, 1);
      end
      tick();
      repeat (3) tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      repeat (2) tick();
      bus.out_ready = 1'b1;
      wait_idle();
      expect_bytes("t4", 24'h000578);
      check("t4_mac_en_pulses", 32'(en_cnt), 2);

      // 5: freezes mid-LOAD and mid-OUT, same result as test 1
      frozen_cnt = 0;
      send_cmd(3'd3);
      send_pair(8'd2, 8'd3);
      ena = 1'b0;
      repeat (5) tick();
      ena = 1'b1;
      send_pair(8'd4, 8'd5); send_pair(8'd6, 8'd7);
      begin
         bit got = 1'b0;
         for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rx_q.size() == 1) got = 1'b1;
         end
         if (!got) check("t5_byte_timeout", 0, 1);
      end
      tick();
      ena = 1'b0;
      repeat (5) tick();
      ena = 1'b1;
      wait_idle();
      expect_bytes("t5", 24'h000044);
      check("t5_frozen_mac_en", 32'(frozen_cnt), 0);

      // 6: reset during DRAIN, then len 1 (1,1)
      send_cmd(3'd2);
      send_pair(8'd3, 8'd3); send_pair(8'd3, 8'd3);
      ov_cnt = 0;
      tick();
      rst_n = 1'b0;
      #1;
      check("t6_busy_in_reset", 32'(bus.busy), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("t6_no_out_valid", 32'(ov_cnt), 0);
      check("t6_no_bytes", 32'(rx_q.size()), 0);
      send_cmd(3'd1);
      send_pair(8'd1, 8'd1);
      wait_idle();
      expect_bytes("t6", 24'h000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
